coax_trig_tx: RTL and testbench
===============================

// Module: coax_trig_tx
// PURPOSE
//  Digitizer-board side of the coax/LVDS trigger link: turns per-channel discriminator hits into
//  fixed-width, dead-timed pulses on coax_out toward the trigger board's per-channel inputs.
//  Adds per-channel enable, a forced (rolling/test) fire, and sent/missed counters for slow readout.
// PARAMETERS
//  NCH      16  number of coax trigger channels
//  CNTW     32  width of per-channel sent/missed counters
// PORTS
//  clk_adc    in   1        sole clock; all logic on rising edge
//  nrst       in   1        asynchronous, active-low reset
//  hit        in   NCH      discriminator level per channel (rising edge = hit)
//  chan_en    in   NCH      per-channel enable (slow-clock domain, quasi-static)
//  pulse_len  in   4        coax pulse width in clk_adc ticks (0 treated as 1)
//  holdoff    in   8        dead ticks after pulse before channel re-arms
//  force_fire in   1        one-tick strobe: fire every enabled IDLE channel
//  resetcnt   in   1        synchronous clear of all counters
//  cntsel     in   8        readout select: [7]=0 sent,1 missed; [3:0]=channel
//  coax_out   out  NCH      registered trigger pulses to coax/LVDS drivers
//  cnt_out    out  CNTW     registered selected counter value
// BEHAVIOUR
//  Reset (nrst=0, async): coax_out=0, cnt_out=0, all counters 0, all channels IDLE, input regs 0.
//  Input stage: hit, chan_en, pulse_len, holdoff, cntsel registered once (timing, as slow-clk sourced).
//  Edge: edge[i] = hit_r[i] & ~hit_rd[i]; trig[i] = chan_en_r[i] & (edge[i] | force_fire).
//  Per-channel FSM (state, 8-bit tick counter):
//   IDLE: trig -> FIRE, cnt=max(pulse_len_r,1)-1, sent++ ; coax_out[i]<=1 same edge.
//   FIRE: coax_out=1; cnt==0 -> (holdoff_r==0 ? IDLE : DEAD, cnt=holdoff_r-1) else cnt--.
//   DEAD: coax_out=0; cnt==0 -> IDLE else cnt--.
//   pulse_len/holdoff latched at state entry; mid-pulse config changes take effect on next trigger.
//  Latency: hit rises before edge k -> hit_r at k -> hit_rd at k+1 -> coax_out high after edge k+1
//   (2 ticks); force_fire seen at edge k -> coax_out high after edge k. Width exactly pulse_len ticks.
//  Missed: trig while in FIRE or DEAD (incl. last DEAD tick) -> missed++; no retrigger, no extension.
//  Disabled channel: trig suppressed, not counted; disabling mid-pulse does not truncate pulse.
//  Counters: saturate at all-ones; resetcnt has priority over same-cycle increment.
//  Readout: cnt_out <= selected counter, 1-tick latency after cntsel_r; cntsel[6:4] ignored.
//  force_fire coincident with edge: one fire, sent+1 only (not missed).
//  Reset mid-pulse: coax_out drops asynchronously, channel IDLE, no dead time retained.
// STRUCTURE
//  Package coax_trig_pkg: typedef enum {TX_IDLE,TX_FIRE,TX_DEAD} tx_state_t; NCH, CNTW,
//   PULSEW=4, HOLDW=8 constants; saturating-increment function.
//  Sub-module coax_tx_chan (one channel: FSM, tick counter, sent/missed counters), generated NCH times;
//   top holds input registers, edge detect, force_fire fan-out, readout mux.
// TESTING
//  1. chan_en=FFFF, pulse_len=3, holdoff=5; hit[2] rises once -> coax_out[2] high 3 ticks starting 2 ticks
//     later, others 0; sent[2]=1, missed[2]=0.
//  2. Same cfg; hit[2] re-edges 4 ticks after first -> no second pulse, missed[2]=1; edge 10 ticks after
//     first -> second pulse, sent[2]=2.
//  3. pulse_len=0, holdoff=0; hit[5] toggles every 2 ticks -> 1-tick pulses each edge, missed[5]=0.
//  4. chan_en=0x0001, force_fire 1 tick -> only coax_out[0] pulses, next tick; sent[0]=1, others 0.
//  5. Preload sent[7]=FFFFFFFF via force; one more trig -> stays FFFFFFFF; resetcnt with trig same
//     tick -> 0; cntsel=0x87 reads missed[7] one tick later.
//  6. nrst low during FIRE of ch 3 -> coax_out[3]=0 immediately, counters 0; after release, hit edge
//     fires normally with no holdoff.

Source files
------------

// File: rtl/coax_trig_pkg.sv
// Shared definitions for the coax trigger transmitter.
// Provides the default channel count and counter width, the pulse/holdoff
// field widths, the per-channel state encoding and a saturating increment.
package coax_trig_pkg;

  localparam int NCH    = 16;
  localparam int CNTW   = 32;
  localparam int PULSEW = 4;
  localparam int HOLDW  = 8;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_FIRE = 2'd1,
    TX_DEAD = 2'd2
  } tx_state_t;

  // Increment that sticks at all-ones; the caller says whether v is already full,
  // so narrower counters can share this helper after zero-extension.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic is_full);
    if (is_full) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNTW'(1);
    end
  endfunction

endpackage

// File: rtl/coax_trig_if.sv
// Bundle of the trigger link's data/config signals.
//   hit, chan_en, pulse_len, holdoff, force_fire, resetcnt, cntsel : toward transmitter
//   coax_out, cnt_out                                              : from transmitter
// slave modport is the transmitter, master modport is whoever drives it.
interface coax_trig_if #(
  parameter int NCH  = coax_trig_pkg::NCH,
  parameter int CNTW = coax_trig_pkg::CNTW
);
  import coax_trig_pkg::*;

  logic [NCH-1:0]    hit;
  logic [NCH-1:0]    chan_en;
  logic [PULSEW-1:0] pulse_len;
  logic [HOLDW-1:0]  holdoff;
  logic              force_fire;
  logic              resetcnt;
  logic [7:0]        cntsel;
  logic [NCH-1:0]    coax_out;
  logic [CNTW-1:0]   cnt_out;

  modport slave (
    input  hit, chan_en, pulse_len, holdoff, force_fire, resetcnt, cntsel,
    output coax_out, cnt_out
  );

  modport master (
    output hit, chan_en, pulse_len, holdoff, force_fire, resetcnt, cntsel,
    input  coax_out, cnt_out
  );
endinterface

// File: rtl/coax_tx_chan.sv
// One coax trigger channel: IDLE/FIRE/DEAD pulse shaper plus sent/missed counters.
//   clk_adc, nrst : clock, async active-low reset
//   i_trig        : qualified trigger for this channel (already enabled/edge-detected)
//   i_len, i_hold : registered pulse width / holdoff, captured when a pulse starts
//   i_resetcnt    : synchronous counter clear, wins over increments
//   o_coax        : registered pulse output
//   o_sent/o_missed : saturating counters
module coax_tx_chan
  import coax_trig_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic              clk_adc,
  input  logic              nrst,
  input  logic              i_trig,
  input  logic [PULSEW-1:0] i_len,
  input  logic [HOLDW-1:0]  i_hold,
  input  logic              i_resetcnt,
  output logic              o_coax,
  output logic [CW-1:0]     o_sent,
  output logic [CW-1:0]     o_missed
);

  tx_state_t        r_state, w_state_nxt;
  logic [HOLDW-1:0] r_tick, w_tick_nxt;
  logic [HOLDW-1:0] r_hold, w_hold_nxt;
  logic             r_coax;
  logic [CW-1:0]    r_sent, r_missed;
  logic             w_fire, w_miss;

  // Next-state logic; holdoff is captured at fire time so mid-pulse edits wait for the next trigger.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_hold_nxt  = r_hold;
    w_fire      = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_trig) begin
          w_state_nxt = TX_FIRE;
          w_tick_nxt  = (i_len == 4'd0) ? 8'd0 : (HOLDW'(i_len) - 8'd1);
          w_hold_nxt  = i_hold;
          w_fire      = 1'b1;
        end else begin
          w_state_nxt = TX_IDLE;
        end
      end
      TX_FIRE: begin
        w_miss = i_trig;
        if (r_tick == 8'd0) begin
          if (r_hold == 8'd0) begin
            w_state_nxt = TX_IDLE;
          end else begin
            w_state_nxt = TX_DEAD;
            w_tick_nxt  = r_hold - 8'd1;
          end
        end else begin
          w_tick_nxt = r_tick - 8'd1;
        end
      end
      TX_DEAD: begin
        w_miss = i_trig;
        if (r_tick == 8'd0) begin
          w_state_nxt = TX_IDLE;
        end else begin
          w_tick_nxt = r_tick - 8'd1;
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_tick_nxt  = 8'd0;
      end
    endcase
  end

  // State, tick counter and pulse output registers; output goes high on the firing edge itself.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_state <= TX_IDLE;
      r_tick  <= 8'd0;
      r_hold  <= 8'd0;
      r_coax  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_hold  <= w_hold_nxt;
      r_coax  <= (w_state_nxt == TX_FIRE);
    end
  end

  // Sent/missed counters with clear priority over increment.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_sent   <= '0;
      r_missed <= '0;
    end else if (i_resetcnt) begin
      r_sent   <= '0;
      r_missed <= '0;
    end else begin
      if (w_fire) begin
        r_sent <= CW'(sat_inc(CNTW'(r_sent), &r_sent));
      end
      if (w_miss) begin
        r_missed <= CW'(sat_inc(CNTW'(r_missed), &r_missed));
      end
    end
  end

  assign o_coax   = r_coax;
  assign o_sent   = r_sent;
  assign o_missed = r_missed;

endmodule

// File: rtl/coax_trig_tx.sv
// Digitizer-side coax trigger transmitter.
//   clk_adc : sole clock        nrst : async active-low reset
//   bus     : coax_trig_if slave (hit/chan_en/pulse_len/holdoff/force_fire/resetcnt/cntsel in,
//             coax_out/cnt_out out)
// Registers the slow-domain inputs, detects hit rising edges, fans out force_fire,
// runs one coax_tx_chan per channel and muxes one counter onto cnt_out.
module coax_trig_tx #(
  parameter int NCH  = coax_trig_pkg::NCH,
  parameter int CNTW = coax_trig_pkg::CNTW
) (
  input  logic        clk_adc,
  input  logic        nrst,
  coax_trig_if.slave  bus
);
  import coax_trig_pkg::*;

  logic [NCH-1:0]    r_hit, r_hit_d, r_en;
  logic [PULSEW-1:0] r_len;
  logic [HOLDW-1:0]  r_hold;
  logic [4:0]        r_sel;   // {missed-select, channel}; cntsel[6:4] has no meaning
  logic [CNTW-1:0]   r_cnt;
  logic [NCH-1:0]    w_edge, w_trig, w_coax;
  logic [CNTW-1:0]   w_sent   [NCH];
  logic [CNTW-1:0]   w_missed [NCH];

  // Input stage: one register on everything sourced from the slow domain, plus the edge-delay stage.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_hit   <= '0;
      r_hit_d <= '0;
      r_en    <= '0;
      r_len   <= 4'd0;
      r_hold  <= 8'd0;
      r_sel   <= 5'd0;
    end else begin
      r_hit   <= bus.hit;
      r_hit_d <= r_hit;
      r_en    <= bus.chan_en;
      r_len   <= bus.pulse_len;
      r_hold  <= bus.holdoff;
      r_sel   <= {bus.cntsel[7], bus.cntsel[3:0]};
    end
  end

  // force_fire is a direct strobe, so it fires one edge earlier than a hit.
  assign w_edge = r_hit & ~r_hit_d;
  assign w_trig = r_en & (w_edge | {NCH{bus.force_fire}});

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    coax_tx_chan #(.CW(CNTW)) u_chan (
      .clk_adc    (clk_adc),
      .nrst       (nrst),
      .i_trig     (w_trig[gi]),
      .i_len      (r_len),
      .i_hold     (r_hold),
      .i_resetcnt (bus.resetcnt),
      .o_coax     (w_coax[gi]),
      .o_sent     (w_sent[gi]),
      .o_missed   (w_missed[gi])
    );
  end

  // Readout register: selected counter one tick after the select is registered.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (r_sel[4]) begin
      r_cnt <= w_missed[r_sel[3:0]];
    end else begin
      r_cnt <= w_sent[r_sel[3:0]];
    end
  end

  assign bus.coax_out = w_coax;
  assign bus.cnt_out  = r_cnt;

endmodule

// File: tb/tb_coax_trig_tx.sv
module tb_coax_trig_tx;

  logic        clk_adc = 1'b0;
  logic        nrst    = 1'b0;
  logic [15:0] hit = 16'h0, chan_en = 16'h0;
  logic [3:0]  pulse_len = 4'd0;
  logic [7:0]  holdoff = 8'd0, cntsel = 8'd0;
  logic        force_fire = 1'b0, resetcnt = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_adc = ~clk_adc;

  coax_trig_if #(.NCH(16), .CNTW(32)) bus_m ();
  coax_trig_if #(.NCH(16), .CNTW(4))  bus_s ();

  assign bus_m.hit = hit;        assign bus_s.hit = hit;
  assign bus_m.chan_en = chan_en; assign bus_s.chan_en = chan_en;
  assign bus_m.pulse_len = pulse_len; assign bus_s.pulse_len = pulse_len;
  assign bus_m.holdoff = holdoff; assign bus_s.holdoff = holdoff;
  assign bus_m.force_fire = force_fire; assign bus_s.force_fire = force_fire;
  assign bus_m.resetcnt = resetcnt; assign bus_s.resetcnt = resetcnt;
  assign bus_m.cntsel = cntsel;   assign bus_s.cntsel = cntsel;

  // Full-size instance plus a 4-bit-counter instance to exercise saturation quickly.
  coax_trig_tx #(.NCH(16), .CNTW(32)) dut (.clk_adc(clk_adc), .nrst(nrst), .bus(bus_m));
  coax_trig_tx #(.NCH(16), .CNTW(4))  dut_s (.clk_adc(clk_adc), .nrst(nrst), .bus(bus_s));

  // Reference model: per channel, the edge index until which the pulse is high and
  // the first edge index at which a new trigger is accepted; unsaturated event counts.
  longint k;
  longint m_hi_to [16];
  longint m_busy_to [16];
  longint m_sent [16];
  longint m_missed [16];
  logic [15:0] m_hit_r, m_hit_rd, m_en_r;
  logic [3:0]  m_len_r;
  logic [7:0]  m_hold_r, m_sel_r;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_hi_to[i] = 0; m_busy_to[i] = 0; m_sent[i] = 0; m_missed[i] = 0;
    end
    m_hit_r = '0; m_hit_rd = '0; m_en_r = '0;
    m_len_r = '0; m_hold_r = '0; m_sel_r = '0;
  endtask

  // Advance one clock: predict, clock, then compare all outputs.
  task automatic tick();
    logic [15:0] trig_v, exp_coax;
    longint v, width;
    int ch;
    trig_v = m_en_r & ((m_hit_r & ~m_hit_rd) | {16{force_fire}});
    ch = int'(m_sel_r[3:0]);
    v  = m_sel_r[7] ? m_missed[ch] : m_sent[ch];
    width = (m_len_r == 4'd0) ? 1 : longint'(m_len_r);
    for (int i = 0; i < 16; i++) begin
      if (trig_v[i]) begin
        if (k >= m_busy_to[i]) begin
          m_hi_to[i]   = k + width;
          m_busy_to[i] = k + width + longint'(m_hold_r) + 1;
          m_sent[i]++;
        end else begin
          m_missed[i]++;
        end
      end
      if (resetcnt) begin
        m_sent[i] = 0; m_missed[i] = 0;
      end
      exp_coax[i] = (k < m_hi_to[i]);
    end
    m_hit_rd = m_hit_r; m_hit_r = hit; m_en_r = chan_en;
    m_len_r = pulse_len; m_hold_r = holdoff; m_sel_r = cntsel;
    k++;
    @(posedge clk_adc);
    #1;
    check_val("coax_out", 64'(bus_m.coax_out), 64'(exp_coax));
    check_val("cnt_out", 64'(bus_m.cnt_out), 64'(v[31:0]));
    check_val("cnt_out_sat4", 64'(bus_s.cnt_out), (v > 15) ? 64'd15 : 64'(v));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Select a counter and check the value read out two ticks later.
  task automatic read_cnt(input string tag, input logic [7:0] sel, input longint exp);
    cntsel = sel;
    ticks(2);
    check_val(tag, 64'(bus_m.cnt_out), 64'(exp));
    check_val({tag, "_sat4"}, 64'(bus_s.cnt_out), (exp > 15) ? 64'd15 : 64'(exp));
  endtask

  task automatic do_reset();
    #3;
    nrst = 1'b0;
    #1;
    check_val("rst_coax", 64'(bus_m.coax_out), 64'd0);
    check_val("rst_cnt", 64'(bus_m.cnt_out), 64'd0);
    model_reset();
    @(posedge clk_adc);
    @(posedge clk_adc);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    k = 0;
    model_reset();
    @(posedge clk_adc);
    @(posedge clk_adc);
    #1;
    check_val("reset_coax", 64'(bus_m.coax_out), 64'd0);
    check_val("reset_cnt", 64'(bus_m.cnt_out), 64'd0);
    nrst = 1'b1;

    // 1: single hit, 3-tick pulse two ticks later
    chan_en = 16'hFFFF; pulse_len = 4'd3; holdoff = 8'd5;
    ticks(3);
    hit[2] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check_val("t1_ch2", 64'(bus_m.coax_out[2]), 64'((j >= 2) && (j <= 4)));
      check_val("t1_others", 64'(bus_m.coax_out & 16'hFFFB), 64'd0);
    end
    hit[2] = 1'b0;
    ticks(10);
    read_cnt("t1_sent2", 8'h02, 1);
    read_cnt("t1_missed2", 8'h82, 0);

    // 2: re-edge during pulse/dead time is missed, later edge fires again
    resetcnt = 1'b1; tick(); resetcnt = 1'b0;
    for (int j = 0; j < 24; j++) begin
      hit[2] = (j < 2) || (j >= 4 && j < 6) || (j >= 10 && j < 12);
      tick();
    end
    read_cnt("t2_sent2", 8'h02, 2);
    read_cnt("t2_missed2", 8'h82, 1);

    // 3: zero length/holdoff -> 1-tick pulses per edge, nothing missed
    pulse_len = 4'd0; holdoff = 8'd0;
    ticks(2);
    for (int j = 0; j < 24; j++) begin
      if (j % 2 == 0) hit[5] = ~hit[5];
      tick();
    end
    hit[5] = 1'b0;
    ticks(3);
    read_cnt("t3_missed5", 8'h85, 0);
    read_cnt("t3_sent5", 8'h05, 6);

    // 4: force_fire with a single enabled channel
    chan_en = 16'h0001;
    ticks(2);
    resetcnt = 1'b1; tick(); resetcnt = 1'b0;
    force_fire = 1'b1; tick(); force_fire = 1'b0;
    check_val("t4_force", 64'(bus_m.coax_out), 64'h1);
    tick();
    check_val("t4_after", 64'(bus_m.coax_out), 64'h0);
    read_cnt("t4_sent0", 8'h00, 1);
    read_cnt("t4_sent1", 8'h01, 0);

    // 5: saturation, clear priority, missed readout
    chan_en = 16'h0080; pulse_len = 4'd1; holdoff = 8'd0;
    ticks(2);
    resetcnt = 1'b1; tick(); resetcnt = 1'b0;
    for (int j = 0; j < 20; j++) begin
      force_fire = 1'b1; tick(); force_fire = 1'b0; tick();
    end
    read_cnt("t5_sent7", 8'h07, 20);
    force_fire = 1'b1; resetcnt = 1'b1; tick();
    force_fire = 1'b0; resetcnt = 1'b0; ticks(2);
    read_cnt("t5_clr7", 8'h07, 0);
    force_fire = 1'b1; ticks(2); force_fire = 1'b0; ticks(2);
    read_cnt("t5_missed7", 8'h87, 1);

    // 6: reset in the middle of a pulse
    chan_en = 16'hFFFF; pulse_len = 4'd8; holdoff = 8'd20;
    ticks(2);
    hit[3] = 1'b1;
    ticks(3);
    check_val("t6_firing", 64'(bus_m.coax_out[3]), 64'd1);
    hit[3] = 1'b0;
    do_reset();
    ticks(2);
    hit[3] = 1'b1;
    ticks(2);
    check_val("t6_refire", 64'(bus_m.coax_out[3]), 64'd1);
    hit[3] = 1'b0;
    ticks(30);

    // Randomized traffic against the model
    for (int j = 0; j < 3000; j++) begin
      hit = hit ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 199) == 0) chan_en = 16'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_len = 4'($urandom);
      if ($urandom_range(0, 99) == 0) holdoff = 8'($urandom_range(0, 12));
      force_fire = ($urandom_range(0, 29) == 0);
      resetcnt = ($urandom_range(0, 299) == 0);
      cntsel = 8'($urandom);
      if (j == 1500) begin
        force_fire = 1'b0; resetcnt = 1'b0;
        do_reset();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
